// File: rtl/fp_div_pkg.sv
// Shared constants, defaults and state encoding for the iterative binary32 divider.
package fp_div_pkg;

  localparam int D_WIDTH = 32;
  localparam int M_WIDTH = 23;
  localparam int E_WIDTH = 8;
  localparam int BIAS    = 127;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  // Quotient bits produced: one integer bit plus 24 fraction bits.
  localparam int DIV_ITERS = 25;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    DIV,
    NORM
  } state_e;

endpackage

// File: rtl/fp_div_mantissa_core.sv
// Restoring mantissa divider: one quotient bit per step, remainder and quotient held here.
module fp_div_mantissa_core #(
  parameter int M_WIDTH = fp_div_pkg::M_WIDTH
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic [M_WIDTH:0]   a,
  input  logic [M_WIDTH:0]   b,
  output logic [M_WIDTH+1:0] q
);
  import fp_div_pkg::*;

  logic [M_WIDTH+1:0] r_q, r_d;
  logic [M_WIDTH+1:0] q_q;
  logic [M_WIDTH+1:0] b_ext;
  logic               q_bit;

  assign b_ext = {1'b0, b};
  assign q_bit = (r_q >= b_ext);
  // After the conditional subtract the remainder is always below B, so its MSB is zero.
  assign r_d   = q_bit ? (r_q - b_ext) : r_q;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_q <= '0;
      q_q <= '0;
    end else if (load) begin
      r_q <= {1'b0, a};
      q_q <= '0;
    end else if (step) begin
      r_q <= {r_d[M_WIDTH:0], 1'b0};
      q_q <= {q_q[M_WIDTH:0], q_bit};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fp_divider.sv
// Iterative binary32 divider with start/done handshake, truncating result, fixed 28-cycle latency.
module fp_divider #(
  parameter int D_WIDTH = fp_div_pkg::D_WIDTH,
  parameter int M_WIDTH = fp_div_pkg::M_WIDTH,
  parameter int E_WIDTH = fp_div_pkg::E_WIDTH,
  parameter int BIAS    = fp_div_pkg::BIAS
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               start,
  input  logic [D_WIDTH-1:0] dividend_in,
  input  logic [D_WIDTH-1:0] divisor_in,
  output logic               busy,
  output logic               done,
  output logic [D_WIDTH-1:0] result_out
);
  import fp_div_pkg::*;

  localparam int XW = E_WIDTH + 2;
  localparam int CW = $clog2(DIV_ITERS);

  state_e              state_q;
  logic                busy_q, done_q, fin_q, sign_q, special_q;
  logic [D_WIDTH-1:0]  a_q, b_q, result_q, pend_q, special_res_q;
  logic [CW-1:0]       cnt_q;
  logic signed [XW-1:0] exp_q;

  logic [E_WIDTH-1:0]  ea, eb;
  logic                sign_d, a_zero, b_zero, a_infnan, b_infnan;
  logic signed [XW-1:0] exp_d, exp_fin;
  logic                special_d;
  logic [D_WIDTH-1:0]  special_res_d, norm_res;
  logic [M_WIDTH+1:0]  q_core;
  logic [M_WIDTH-1:0]  mant;

  assign ea       = a_q[D_WIDTH-2 -: E_WIDTH];
  assign eb       = b_q[D_WIDTH-2 -: E_WIDTH];
  assign sign_d   = a_q[D_WIDTH-1] ^ b_q[D_WIDTH-1];
  assign a_zero   = (ea == '0);
  assign b_zero   = (eb == '0);
  assign a_infnan = (ea == EXP_MAX);
  assign b_infnan = (eb == EXP_MAX);
  assign exp_d    = $signed(XW'(ea) - XW'(eb) + XW'(BIAS));

  always_comb begin
    special_d     = 1'b1;
    special_res_d = '0;
    if (a_infnan || b_infnan || (a_zero && b_zero)) begin
      special_res_d = FP_QNAN;
    end else if (b_zero) begin
      special_res_d = {sign_d, EXP_MAX, {M_WIDTH{1'b0}}};
    end else if (a_zero) begin
      special_res_d = {sign_d, {E_WIDTH{1'b0}}, {M_WIDTH{1'b0}}};
    end else begin
      special_d = 1'b0;
    end
  end

  fp_div_mantissa_core #(
    .M_WIDTH(M_WIDTH)
  ) u_core (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .load   (state_q == PREP),
    .step   (state_q == DIV),
    .a      ({1'b1, a_q[M_WIDTH-1:0]}),
    .b      ({1'b1, b_q[M_WIDTH-1:0]}),
    .q      (q_core)
  );

  // A quotient below 1.0 needs one left shift, which costs one from the exponent.
  always_comb begin
    exp_fin = q_core[M_WIDTH+1] ? exp_q : (exp_q - $signed(XW'(1)));
    mant    = q_core[M_WIDTH+1] ? q_core[M_WIDTH:1] : q_core[M_WIDTH-1:0];
    if (special_q) begin
      norm_res = special_res_q;
    end else if (exp_fin >= $signed(XW'(EXP_MAX))) begin
      norm_res = {sign_q, EXP_MAX, {M_WIDTH{1'b0}}};
    end else if (exp_fin <= $signed(XW'(0))) begin
      norm_res = {sign_q, {E_WIDTH{1'b0}}, {M_WIDTH{1'b0}}};
    end else begin
      norm_res = {sign_q, exp_fin[E_WIDTH-1:0], mant};
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fin_q         <= 1'b0;
      result_q      <= '0;
      pend_q        <= '0;
      a_q           <= '0;
      b_q           <= '0;
      cnt_q         <= '0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      special_q     <= 1'b0;
      special_res_q <= '0;
    end else begin
      done_q <= 1'b0;
      // Output stage: result published one edge after NORM, busy drops with done.
      if (fin_q) begin
        done_q   <= 1'b1;
        result_q <= pend_q;
        busy_q   <= 1'b0;
        fin_q    <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start && !busy_q) begin
            a_q     <= dividend_in;
            b_q     <= divisor_in;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          sign_q        <= sign_d;
          exp_q         <= exp_d;
          special_q     <= special_d;
          special_res_q <= special_res_d;
          cnt_q         <= CW'(DIV_ITERS - 1);
          state_q       <= DIV;
        end
        DIV: begin
          if (cnt_q == '0) begin
            state_q <= NORM;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        NORM: begin
          pend_q  <= norm_res;
          fin_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result_out = result_q;

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: results, latency, busy window, handshake and reset abort.
module tb_fp_divider;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] dividend_in;
  logic [31:0] divisor_in;
  logic        busy;
  logic        done;
  logic [31:0] result_out;

  typedef struct {
    logic [31:0] res;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  fp_divider dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .start      (start),
    .dividend_in(dividend_in),
    .divisor_in (divisor_in),
    .busy       (busy),
    .done       (done),
    .result_out (result_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, expv);
  endtask

  // Scoreboard: each done pops the oldest accepted request.
  always @(negedge clk_in) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("done: result=%h expected=%h latency=%0d", result_out, e.res, cyc - e.t0);
        chk("result", result_out, e.res);
        chk("latency", cyc - e.t0, 28);
        chk("busy_at_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic wait_done(input bit check_busy);
    int bc;
    bit seen;
    bc = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) bc++;
      @(negedge clk_in);
    end
    chk("done_seen", {31'b0, seen}, 32'd1);
    if (check_busy) chk("busy_cycles", bc, 28);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    exp_t e;
    start       = 1'b1;
    dividend_in = a;
    divisor_in  = b;
    e.res = r;
    e.t0  = cyc + 1;
    sb.push_back(e);
    $display("start: %h / %h expect %h", a, b, r);
    @(negedge clk_in);
    start       = 1'b0;
    dividend_in = $urandom;
    divisor_in  = $urandom;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    @(negedge clk_in);
    issue(a, b, r);
    wait_done(1'b1);
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result_out, 32'd0);
    reset_n = 1'b1;

    do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
    do_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);
    do_op(32'hBF80_0000, 32'h3F00_0000, 32'hC000_0000);
    do_op(32'h4000_0000, 32'h0000_0000, 32'h7F80_0000);
    do_op(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000);
    do_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
    do_op(32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000);
    do_op(32'h3F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    do_op(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000);
    do_op(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000);
    do_op(32'hC0C0_0000, 32'hC000_0000, 32'h4040_0000);

    // A second start while busy must not recapture operands.
    @(negedge clk_in);
    issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
    repeat (8) @(negedge clk_in);
    start       = 1'b1;
    dividend_in = 32'h3F80_0000;
    divisor_in  = 32'h4040_0000;
    @(negedge clk_in);
    start = 1'b0;
    wait_done(1'b0);

    // Start in the done cycle is accepted.
    issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);
    wait_done(1'b0);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk_in);
    start       = 1'b1;
    dividend_in = 32'h40C0_0000;
    divisor_in  = 32'h4000_0000;
    @(negedge clk_in);
    start = 1'b0;
    repeat (14) @(negedge clk_in);
    reset_n = 1'b0;
    @(negedge clk_in);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_result", result_out, 32'd0);
    reset_n = 1'b1;
    repeat (35) @(negedge clk_in);
    chk("abort_result_held", result_out, 32'd0);

    do_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);

    repeat (3) @(negedge clk_in);
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
